// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle logic/arith/shift ops plus a fixed-latency
// iterative shift-add multiplier, with valid/ready handshakes on both sides
// and a registered writeback result.
module alu_exec_stage #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_control,
   input  logic                  regwrite_control,
   input  logic [WIDTH-1:0]      rs1_data,
   input  logic [WIDTH-1:0]      rs2_data,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      result,
   output logic [REG_ADDR_W-1:0] out_rd_addr,
   output logic                  out_regwrite,
   output logic                  out_zero,
   output logic                  out_illegal
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = SHW + 1;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_HOLD
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [WIDTH-1:0]      r_result;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic                  r_regwrite;
   logic                  r_zero;
   logic                  r_illegal;
   logic [WIDTH-1:0]      r_mcand;
   logic [WIDTH-1:0]      r_mplier;
   logic [WIDTH-1:0]      r_acc;
   logic [CW-1:0]         r_count;

   logic                  w_accept;
   logic                  w_is_mul;
   logic                  w_illegal;
   logic                  w_regwrite;
   logic [SHW-1:0]        w_shamt;
   logic [WIDTH-1:0]      w_alu_result;
   logic [WIDTH-1:0]      w_mul_acc_next;
   logic                  w_mul_last;

   // Handshake: accept only when empty, or when the held result leaves this cycle.
   assign in_ready  = !reset && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
   assign out_valid = (r_state == S_HOLD);
   assign w_accept  = in_valid && in_ready;

   assign w_is_mul   = (alu_control == OP_MUL);
   assign w_illegal  = alu_control[3];
   assign w_regwrite = regwrite_control && (rd_addr != '0) && !w_illegal;
   assign w_shamt    = rs2_data[SHW-1:0];

   assign w_mul_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mul_last     = (r_count == CW'(1));

   // Single-cycle ALU result; MUL and illegal codes yield 0 here.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      w_alu_result = '0;
      case (alu_control)
         OP_AND:  w_alu_result = rs1_data & rs2_data;
         OP_OR:   w_alu_result = rs1_data | rs2_data;
         OP_ADD:  w_alu_result = rs1_data + rs2_data;
         OP_SLL:  w_alu_result = rs1_data << w_shamt;
         OP_SUB:  w_alu_result = rs1_data - rs2_data;
         OP_SRL:  w_alu_result = rs1_data >> w_shamt;
         OP_XOR:  w_alu_result = rs1_data ^ rs2_data;
         default: w_alu_result = '0;
      endcase
   end

   // Next-state logic for IDLE / MUL / HOLD.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = w_is_mul ? S_MUL : S_HOLD;
         end
         S_MUL: begin
            if (w_mul_last) w_next_state = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               if (w_accept) w_next_state = w_is_mul ? S_MUL : S_HOLD;
               else          w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // State, output registers and multiplier datapath.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_state    <= S_IDLE;
         r_result   <= '0;
         r_rd_addr  <= '0;
         r_regwrite <= 1'b0;
         r_zero     <= 1'b0;
         r_illegal  <= 1'b0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_acc      <= '0;
         r_count    <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_rd_addr  <= rd_addr;
            r_regwrite <= w_regwrite;
            r_illegal  <= w_illegal;
            if (w_is_mul) begin
               r_mcand  <= rs1_data;
               r_mplier <= rs2_data;
               r_acc    <= '0;
               r_count  <= CW'(WIDTH);
            end else begin
               r_result <= w_alu_result;
               r_zero   <= (w_alu_result == '0);
            end
         end else if (r_state == S_MUL) begin
            r_acc    <= w_mul_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
            if (w_mul_last) begin
               r_result <= w_mul_acc_next;
               r_zero   <= (w_mul_acc_next == '0);
            end
         end
      end
   end

   assign result       = r_result;
   assign out_rd_addr  = r_rd_addr;
   assign out_regwrite = r_regwrite;
   assign out_zero     = r_zero;
   assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors covering
// single-cycle ops, back-to-back issue, MUL latency, backpressure,
// x0 suppression, illegal codes and reset during MUL.
module tb_alu_exec_stage;

   localparam int WIDTH      = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_BAD = 4'b1010;

   logic                  clk;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            alu_control;
   logic                  regwrite_control;
   logic [WIDTH-1:0]      rs1_data;
   logic [WIDTH-1:0]      rs2_data;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      result;
   logic [REG_ADDR_W-1:0] out_rd_addr;
   logic                  out_regwrite;
   logic                  out_zero;
   logic                  out_illegal;

   int n_total;
   int n_bad;

   alu_exec_stage #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .alu_control      (alu_control),
      .regwrite_control (regwrite_control),
      .rs1_data         (rs1_data),
      .rs2_data         (rs2_data),
      .rd_addr          (rd_addr),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .result           (result),
      .out_rd_addr      (out_rd_addr),
      .out_regwrite     (out_regwrite),
      .out_zero         (out_zero),
      .out_illegal      (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Present an instruction; caller decides when in_valid drops.
   task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [REG_ADDR_W-1:0] rd,
                        input logic rw);
      alu_control      = op;
      rs1_data         = a;
      rs2_data         = b;
      rd_addr          = rd;
      regwrite_control = rw;
      in_valid         = 1'b1;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the full registered output bundle at the next falling edge.
   task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] r,
                            input logic [REG_ADDR_W-1:0] rd, input logic rw,
                            input logic z, input logic ill);
      @(negedge clk);
      check({tag, "_valid"}, 64'(out_valid), 64'(v));
      check({tag, "_result"}, 64'(result), 64'(r));
      check({tag, "_rd"}, 64'(out_rd_addr), 64'(rd));
      check({tag, "_regwrite"}, 64'(out_regwrite), 64'(rw));
      check({tag, "_zero"}, 64'(out_zero), 64'(z));
      check({tag, "_illegal"}, 64'(out_illegal), 64'(ill));
   endtask

   // Wait for out_valid after a MUL accept; checks latency and in_ready low throughout.
   task automatic mul_wait(input string tag);
      int lat;
      int rdy_hi;
      lat    = 0;
      rdy_hi = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
         if (in_ready) rdy_hi++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd32);
      check({tag, "_ready_low"}, 64'(rdy_hi), 64'd0);
   endtask

   initial begin
      int vhi;
      n_total          = 0;
      n_bad            = 0;
      reset            = 1'b1;
      in_valid         = 1'b0;
      out_ready        = 1'b1;
      alu_control      = OP_AND;
      regwrite_control = 1'b0;
      rs1_data         = '0;
      rs2_data         = '0;
      rd_addr          = '0;

      // Reset state
      step();
      step();
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check_out("rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'd1);

      // ADD wrap to zero
      step();
      drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd3, 1'b1);
      step();
      in_valid = 1'b0;
      check_out("add_wrap", 1'b1, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
      step();
      @(negedge clk);
      check("add_drain_valid", 64'(out_valid), 64'd0);

      // Back-to-back SUB, SLL, SRL
      step();
      drive(OP_SUB, 32'd5, 32'd7, 5'd1, 1'b1);
      step();
      drive(OP_SLL, 32'd1, 32'd35, 5'd2, 1'b1);
      check_out("b2b_sub", 1'b1, 32'hFFFF_FFFE, 5'd1, 1'b1, 1'b0, 1'b0);
      check("b2b_sub_ready", 64'(in_ready), 64'd1);
      step();
      drive(OP_SRL, 32'h8000_0000, 32'd31, 5'd3, 1'b1);
      check_out("b2b_sll", 1'b1, 32'h8, 5'd2, 1'b1, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      check_out("b2b_srl", 1'b1, 32'h1, 5'd3, 1'b1, 1'b0, 1'b0);
      step();

      // MUL 0xFFFF * 0x10001
      drive(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 5'd5, 1'b1);
      step();
      in_valid = 1'b0;
      mul_wait("mul1");
      check("mul1_result", 64'(result), 64'hFFFF_FFFF);
      check("mul1_zero", 64'(out_zero), 64'd0);
      check("mul1_rd", 64'(out_rd_addr), 64'd5);
      step();

      // MUL 0x80000000 * 2 -> 0
      drive(OP_MUL, 32'h8000_0000, 32'd2, 5'd6, 1'b1);
      step();
      in_valid = 1'b0;
      mul_wait("mul2");
      check("mul2_result", 64'(result), 64'h0);
      check("mul2_zero", 64'(out_zero), 64'd1);
      step();

      // XOR held under backpressure with a pending ADD
      out_ready = 1'b0;
      drive(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd7, 1'b1);
      step();
      drive(OP_ADD, 32'd10, 32'd20, 5'd9, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_result", 64'(result), 64'h0000_FF00);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         if (i < 4) step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check_out("bp_pending", 1'b1, 32'd30, 5'd9, 1'b1, 1'b0, 1'b0);
      step();

      // Write to x0 suppressed
      drive(OP_ADD, 32'd5, 32'd6, 5'd0, 1'b1);
      step();
      in_valid = 1'b0;
      check_out("x0", 1'b1, 32'd11, 5'd0, 1'b0, 1'b0, 1'b0);
      step();

      // Illegal opcode
      drive(OP_BAD, 32'h1234, 32'h5678, 5'd8, 1'b1);
      step();
      in_valid = 1'b0;
      check_out("illegal", 1'b1, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1);
      step();

      // Reset 10 cycles into a MUL
      drive(OP_AND, 32'hFF, 32'h0F, 5'd2, 1'b0);
      step();
      in_valid = 1'b0;
      check_out("pre_rst_and", 1'b1, 32'h0F, 5'd2, 1'b0, 1'b0, 1'b0);
      step();
      drive(OP_MUL, 32'd3, 32'd5, 5'd4, 1'b1);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) step();
      reset = 1'b1;
      @(negedge clk);
      check("midmul_rst_ready", 64'(in_ready), 64'd0);
      step();
      reset = 1'b0;
      check_out("midmul_rst", 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("post_rst_ready", 64'(in_ready), 64'd1);
      vhi = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) vhi++;
      end
      check("discarded_mul", 64'(vhi), 64'd0);
      step();
      drive(OP_ADD, 32'd2, 32'd2, 5'd1, 1'b1);
      step();
      in_valid = 1'b0;
      check_out("post_rst_add", 1'b1, 32'd4, 5'd1, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
